// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential imem reads, PC-tagged return queue, valid/ready to cpu.
// Latency: issue in cycle N, data written in N+1, head valid from N+2 (no bypass).
// Backpressure: fetch issues only while queue occupancy plus the in-flight read fits DEPTH.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   imem_en, imem_addr, imem_rdata   synchronous instruction memory (rdata one cycle after en)
//   redirect_valid, redirect_pc      cpu fetch restart (flush + refetch)
//   out_valid, out_instr, out_pc,    queue head to cpu, accepted on out_valid && out_ready
//   out_ready
//   count                            queue occupancy (debug/perf)
module fetch_queue #(
  parameter int              WORD     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_en,
  output logic [WORD-1:0]          imem_addr,
  input  logic [WORD-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [WORD-1:0]          redirect_pc,
  output logic                     out_valid,
  output logic [WORD-1:0]          out_instr,
  output logic [WORD-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WORD-1:0] q_instr_q [DEPTH];
  logic [WORD-1:0] q_instr_d [DEPTH];
  logic [WORD-1:0] q_pc_q    [DEPTH];
  logic [WORD-1:0] q_pc_d    [DEPTH];

  logic [CW:0]     credit_used;
  logic            issue;
  logic            wr_en;
  logic            deq_en;
  logic            head_vld;

  // Handshake decode. The in-flight read holds a slot reserved, and a dequeue in
  // the same cycle is not credited, so a returning word always has room.
  // rst_n gates issue so imem_en is low for the whole time reset is held.
  always_comb begin
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue       = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    wr_en       = inflight_q && !redirect_valid;  // a return during redirect is stale
    head_vld    = (count_q != '0);
    deq_en      = head_vld && out_ready && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + WORD'(1);
      inflight_pc_d = fetch_pc_q;
    end

    if (wr_en) begin
      q_instr_d[wr_ptr_q] = imem_rdata;
      q_pc_d[wr_ptr_q]    = inflight_pc_q;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end

    if (deq_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (wr_en && !deq_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && deq_en) begin
      count_d = count_q - CW'(1);
    end

    // Flush: everything queued or in flight is dropped, fetch restarts next cycle.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      q_instr_q     <= q_instr_d;
      q_pc_q        <= q_pc_d;
    end
  end

  // Head data is forced to zero while empty so stale entries never leak out.
  always_comb begin
    imem_en   = issue;
    imem_addr = fetch_pc_q;
    out_valid = head_vld;
    out_instr = head_vld ? q_instr_q[rd_ptr_q] : '0;
    out_pc    = head_vld ? q_pc_q[rd_ptr_q]    : '0;
    count     = count_q;
  end

`ifndef SYNTHESIS
  // A return into a full queue would overwrite the head; the credit check forbids it.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(wr_en && count_q == CW'(DEPTH)))
    else $error("fetch_queue overflow: return with queue full");
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_queue #(.WORD(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[a] = a + 0x100, data one cycle after en.
  initial imem_rdata = 16'h0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr + 16'h0100;
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        en;
    logic [15:0] addr;
    logic        ov;
    logic [15:0] opc;
    logic [15:0] oin;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  task automatic add(input logic rdy, input logic rv, input logic [15:0] rpc,
                     input logic en, input logic [15:0] addr, input logic ov,
                     input logic [15:0] opc, input logic [15:0] oin, input logic [2:0] cnt);
    vec_t v;
    v = '{rdy, rv, rpc, en, addr, ov, opc, oin, cnt};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive inputs at the negedge, sample 1 time unit later (well clear of posedge).
  task automatic apply(input vec_t v, input int cyc);
    out_ready      = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
    chk("imem_en",   cyc, {15'b0, imem_en},   {15'b0, v.en});
    chk("imem_addr", cyc, imem_addr,          v.addr);
    chk("out_valid", cyc, {15'b0, out_valid}, {15'b0, v.ov});
    chk("out_pc",    cyc, out_pc,             v.opc);
    chk("out_instr", cyc, out_instr,          v.oin);
    chk("count",     cyc, {13'b0, count},     {13'b0, v.cnt});
  endtask

  initial begin
    vec_t v;
    // Start with out_ready low: queue fills to 4, fetch stalls at PC 4.
    add(0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0);  // c0
    add(0,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000, 0);  // c1
    add(0,0,16'h0000, 1,16'h0002, 1,16'h0000,16'h0100, 1);  // c2 first out_valid
    add(0,0,16'h0000, 1,16'h0003, 1,16'h0000,16'h0100, 2);
    add(0,0,16'h0000, 0,16'h0004, 1,16'h0000,16'h0100, 3);  // credit exhausted
    for (int k = 0; k < 5; k++)
      add(0,0,16'h0000, 0,16'h0004, 1,16'h0000,16'h0100, 4);
    // Release: 0..3 drain in order, fetch resumes at 4, steady one per cycle.
    add(1,0,16'h0000, 0,16'h0004, 1,16'h0000,16'h0100, 4);  // c10
    add(1,0,16'h0000, 1,16'h0004, 1,16'h0001,16'h0101, 3);
    add(1,0,16'h0000, 1,16'h0005, 1,16'h0002,16'h0102, 2);
    add(1,0,16'h0000, 1,16'h0006, 1,16'h0003,16'h0103, 2);
    add(1,0,16'h0000, 1,16'h0007, 1,16'h0004,16'h0104, 2);
    add(1,0,16'h0000, 1,16'h0008, 1,16'h0005,16'h0105, 2);
    // Redirect to 0x40 with a read in flight (PC 8 return is dropped).
    add(1,1,16'h0040, 0,16'h0009, 1,16'h0006,16'h0106, 2);  // c16 = N
    add(1,0,16'h0000, 1,16'h0040, 0,16'h0000,16'h0000, 0);  // N+1
    add(1,0,16'h0000, 1,16'h0041, 0,16'h0000,16'h0000, 0);  // N+2
    add(1,0,16'h0000, 1,16'h0042, 1,16'h0040,16'h0140, 1);  // N+3
    add(1,0,16'h0000, 1,16'h0043, 1,16'h0041,16'h0141, 1);
    // Redirect coinciding with a handshake: head 0x42 is discarded.
    add(0,0,16'h0000, 1,16'h0044, 1,16'h0042,16'h0142, 1);  // c21
    add(1,1,16'h0040, 0,16'h0045, 1,16'h0042,16'h0142, 2);  // c22
    add(1,0,16'h0000, 1,16'h0040, 0,16'h0000,16'h0000, 0);
    add(1,0,16'h0000, 1,16'h0041, 0,16'h0000,16'h0000, 0);
    add(1,0,16'h0000, 1,16'h0042, 1,16'h0040,16'h0140, 1);
    // Back-to-back redirects, last (0xFFFF) wins; PC wraps to 0.
    add(1,1,16'h1234, 0,16'h0043, 1,16'h0041,16'h0141, 1);  // c26
    add(1,1,16'hFFFF, 0,16'h1234, 0,16'h0000,16'h0000, 0);  // c27
    add(1,0,16'h0000, 1,16'hFFFF, 0,16'h0000,16'h0000, 0);
    add(1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0);
    add(1,0,16'h0000, 1,16'h0001, 1,16'hFFFF,16'h00FF, 1);  // c30
    add(1,0,16'h0000, 1,16'h0002, 1,16'h0000,16'h0100, 1);
    add(1,0,16'h0000, 1,16'h0003, 1,16'h0001,16'h0101, 1);
    // Stall to build count=3 ahead of the mid-stream reset.
    add(0,0,16'h0000, 1,16'h0004, 1,16'h0002,16'h0102, 1);  // c33
    add(0,0,16'h0000, 1,16'h0005, 1,16'h0002,16'h0102, 2);  // c34

    // Restart after the mid-stream reset, out_ready=1.
    v = '{1'b1,1'b0,16'h0, 1'b1,16'h0000, 1'b0,16'h0000,16'h0000, 3'd0}; post.push_back(v);
    v = '{1'b1,1'b0,16'h0, 1'b1,16'h0001, 1'b0,16'h0000,16'h0000, 3'd0}; post.push_back(v);
    v = '{1'b1,1'b0,16'h0, 1'b1,16'h0002, 1'b1,16'h0000,16'h0100, 3'd1}; post.push_back(v);
    v = '{1'b1,1'b0,16'h0, 1'b1,16'h0003, 1'b1,16'h0001,16'h0101, 3'd1}; post.push_back(v);
    v = '{1'b1,1'b0,16'h0, 1'b1,16'h0004, 1'b1,16'h0002,16'h0102, 3'd1}; post.push_back(v);

    // Reset state while rst_n is held low.
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst imem_en",   -1, {15'b0, imem_en},   16'h0);
    chk("rst imem_addr", -1, imem_addr,          16'h0);
    chk("rst out_valid", -1, {15'b0, out_valid}, 16'h0);
    chk("rst out_pc",    -1, out_pc,             16'h0);
    chk("rst out_instr", -1, out_instr,          16'h0);
    chk("rst count",     -1, {13'b0, count},     16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      @(negedge clk);
    end

    // c35: count=3, then reset mid-cycle with no clock edge in between.
    v = '{1'b0,1'b0,16'h0, 1'b0,16'h0006, 1'b1,16'h0002,16'h0102, 3'd3};
    apply(v, 35);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async imem_en",   36, {15'b0, imem_en},   16'h0);
    chk("async imem_addr", 36, imem_addr,          16'h0);
    chk("async out_valid", 36, {15'b0, out_valid}, 16'h0);
    chk("async out_pc",    36, out_pc,             16'h0);
    chk("async out_instr", 36, out_instr,          16'h0);
    chk("async count",     36, {13'b0, count},     16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < post.size(); i++) begin
      apply(post[i], 100 + i);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
